// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and the call/return decode used by the RAS
// (and reusable by the main decoder).
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic call;
    logic ret;
  } ras_dec_t;

  // Only jr $ra counts as a return; jr through any other register is ignored.
  function automatic ras_dec_t ras_decode(logic [31:0] instr);
    ras_dec_t d;
    d.call = (instr[31:26] == OP_JAL);
    d.ret  = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FUNCT_JR) &&
             (instr[25:21] == REG_RA);
    return d;
  endfunction
endpackage

// File: rtl/return_addr_stack_if.sv
// Retire-side bus of the return-address stack: retiring instruction in,
// prediction, event pulses and statistics out.
interface return_addr_stack_if #(
  parameter int PTRW = 3,
  parameter int CNTW = 16
) ();
  logic            en;
  logic [31:0]     instr;
  logic [31:0]     pcplus4;
  logic [31:0]     ra_actual;
  logic            pred_valid;
  logic [31:0]     pred_addr;
  logic [PTRW:0]   depth;
  logic            mispredict;
  logic            underflow;
  logic            overflow;
  logic [CNTW-1:0] hit_cnt;
  logic [CNTW-1:0] miss_cnt;

  modport master (
    output en, instr, pcplus4, ra_actual,
    input  pred_valid, pred_addr, depth, mispredict, underflow, overflow,
           hit_cnt, miss_cnt
  );

  modport slave (
    input  en, instr, pcplus4, ra_actual,
    output pred_valid, pred_addr, depth, mispredict, underflow, overflow,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/return_addr_stack_ras_storage.sv
// DEPTH x 32 return-address array: one synchronous write port, one
// combinational read port. Contents are not reset.
module ras_storage #(
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [PTRW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [PTRW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);
  logic [DEPTH-1:0][31:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: jal pushes pc+4, jr $ra pops and predicts; tracks
// over/underflow, mispredicts and saturating hit/miss statistics.
module return_addr_stack
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTRW  = 3,
  parameter int CNTW  = 16
) (
  input logic              clk,
  input logic              reset,
  return_addr_stack_if.slave bus
);
  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

  ras_dec_t        dec;
  logic            push, pop_req, empty, full;
  logic [PTRW-1:0] tos_q, tos_d, top_idx;
  logic [PTRW:0]   depth_q, depth_d;
  logic            mp_q, mp_d, uf_q, uf_d, of_q, of_d;
  logic [CNTW-1:0] hit_q, hit_d, miss_q, miss_d;
  logic [31:0]     top_data;
  logic            pred_valid;
  logic [31:0]     pred_addr;

  function automatic logic [CNTW-1:0] sat_inc(logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign dec     = ras_decode(bus.instr);
  assign push    = bus.en && dec.call;
  assign pop_req = bus.en && dec.ret;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == FULL);
  assign top_idx = tos_q - PTRW'(1);

  ras_storage #(.DEPTH(DEPTH), .PTRW(PTRW)) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (tos_q),
    .wdata_i (bus.pcplus4),
    .raddr_i (top_idx),
    .rdata_o (top_data)
  );

  // Prediction is visible for any jr $ra on instr, retiring or not.
  assign pred_valid = dec.ret && !empty;
  assign pred_addr  = pred_valid ? top_data : '0;

  always_comb begin
    tos_d   = tos_q;
    depth_d = depth_q;
    mp_d    = 1'b0;
    uf_d    = 1'b0;
    of_d    = 1'b0;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (push) begin
      // When full, the write lands on the oldest slot, so tos still advances.
      tos_d = tos_q + PTRW'(1);
      if (full) of_d = 1'b1;
      else      depth_d = depth_q + (PTRW+1)'(1);
    end else if (pop_req) begin
      if (!empty) begin
        tos_d   = top_idx;
        depth_d = depth_q - (PTRW+1)'(1);
        if (pred_addr == bus.ra_actual) begin
          hit_d = sat_inc(hit_q);
        end else begin
          mp_d   = 1'b1;
          miss_d = sat_inc(miss_q);
        end
      end else begin
        uf_d   = 1'b1;
        miss_d = sat_inc(miss_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q   <= '0;
      depth_q <= '0;
      mp_q    <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      tos_q   <= tos_d;
      depth_q <= depth_d;
      mp_q    <= mp_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.pred_valid = pred_valid;
  assign bus.pred_addr  = pred_addr;
  assign bus.depth      = depth_q;
  assign bus.mispredict = mp_q;
  assign bus.underflow  = uf_q;
  assign bus.overflow   = of_q;
  assign bus.hit_cnt    = hit_q;
  assign bus.miss_cnt   = miss_q;
endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_return_addr_stack;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;
  localparam int CNTW  = 16;
  localparam logic [31:0] JR_RA = 32'h03E0_0008;
  localparam logic [31:0] JR_T0 = 32'h0100_0008;
  localparam logic [31:0] JAL   = 32'h0C00_0004;
  localparam logic [31:0] ADDI  = 32'h2008_0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  return_addr_stack_if #(.PTRW(PTRW), .CNTW(CNTW)) rif ();

  return_addr_stack #(.DEPTH(DEPTH), .PTRW(PTRW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded queue of return addresses (back = top).
  logic [31:0] m_stk[$];
  int m_hit = 0, m_miss = 0;
  bit e_mp = 0, e_uf = 0, e_of = 0;

  function automatic bit m_call(logic [31:0] i);
    return i[31:26] == 6'd3;
  endfunction
  function automatic bit m_ret(logic [31:0] i);
    return i[31:26] == 6'd0 && i[5:0] == 6'd8 && i[25:21] == 5'd31;
  endfunction
  function automatic int sat(int v);
    return (v >= (1 << CNTW) - 1) ? v : v + 1;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_stk.delete();
        m_hit = 0; m_miss = 0;
        e_mp = 0; e_uf = 0; e_of = 0;
      end else begin
        e_mp = 0; e_uf = 0; e_of = 0;
        if (rif.en && m_call(rif.instr)) begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            e_of = 1;
          end
          m_stk.push_back(rif.pcplus4);
        end else if (rif.en && m_ret(rif.instr)) begin
          if (m_stk.size() > 0) begin
            if (m_stk.pop_back() == rif.ra_actual) m_hit = sat(m_hit);
            else begin
              e_mp = 1;
              m_miss = sat(m_miss);
            end
          end else begin
            e_uf = 1;
            m_miss = sat(m_miss);
          end
        end
      end
    end
  end

  // Per-cycle comparison, mid-cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit pv;
        logic [31:0] pa;
        pv = m_ret(rif.instr) && m_stk.size() > 0;
        pa = pv ? m_stk[$] : 32'h0;
        chk("model pred_valid", 32'(rif.pred_valid), 32'(pv));
        chk("model pred_addr", rif.pred_addr, pa);
        chk("model depth", 32'(rif.depth), 32'(m_stk.size()));
        chk("model mispredict", 32'(rif.mispredict), 32'(e_mp));
        chk("model underflow", 32'(rif.underflow), 32'(e_uf));
        chk("model overflow", 32'(rif.overflow), 32'(e_of));
        chk("model hit_cnt", 32'(rif.hit_cnt), 32'(m_hit));
        chk("model miss_cnt", 32'(rif.miss_cnt), 32'(m_miss));
      end
    end
  end

  // Drive one retiring slot just after the edge; lasts until the next call.
  task automatic step(logic en, logic [31:0] instr, logic [31:0] pc4, logic [31:0] ra);
    @(posedge clk);
    #2;
    rif.en = en; rif.instr = instr; rif.pcplus4 = pc4; rif.ra_actual = ra;
  endtask

  task automatic idle();
    step(1'b0, ADDI, 32'h0, 32'h0);
  endtask

  initial begin
    rif.en = 1'b0; rif.instr = ADDI; rif.pcplus4 = '0; rif.ra_actual = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    chk("reset depth", 32'(rif.depth), 32'd0);
    chk("reset pred_valid", 32'(rif.pred_valid), 32'd0);
    chk("reset hit_cnt", 32'(rif.hit_cnt), 32'd0);
    chk("reset miss_cnt", 32'(rif.miss_cnt), 32'd0);

    // Underflow on an empty stack, then two back-to-back underflows.
    step(1'b1, JR_RA, 32'h0, 32'h40);
    #1 chk("empty jr pred_valid", 32'(rif.pred_valid), 32'd0);
    idle();
    chk("underflow pulse", 32'(rif.underflow), 32'd1);
    chk("underflow miss_cnt", 32'(rif.miss_cnt), 32'd1);
    chk("underflow depth", 32'(rif.depth), 32'd0);
    step(1'b1, JR_RA, 32'h0, 32'h40);
    step(1'b1, JR_RA, 32'h0, 32'h40);
    idle();
    chk("b2b underflow miss_cnt", 32'(rif.miss_cnt), 32'd3);

    // Single call/return hit.
    step(1'b1, JAL, 32'h14, 32'h0);
    step(1'b1, JR_RA, 32'h0, 32'h14);
    #1 chk("hit pred_valid", 32'(rif.pred_valid), 32'd1);
    chk("hit pred_addr", rif.pred_addr, 32'h14);
    idle();
    chk("hit hit_cnt", 32'(rif.hit_cnt), 32'd1);
    chk("hit mispredict", 32'(rif.mispredict), 32'd0);
    chk("hit depth", 32'(rif.depth), 32'd0);

    // Nested calls return in LIFO order.
    for (int i = 1; i <= 3; i++) step(1'b1, JAL, 32'h4 + 32'(i) * 32'h10, 32'h0);
    for (int i = 3; i >= 1; i--) begin
      step(1'b1, JR_RA, 32'h0, 32'h4 + 32'(i) * 32'h10);
      #1 chk("nested pred_addr", rif.pred_addr, 32'h4 + 32'(i) * 32'h10);
    end
    idle();
    chk("nested hit_cnt", 32'(rif.hit_cnt), 32'd4);

    // DEPTH+1 pushes wrap tos and drop the oldest entry.
    for (int i = 0; i <= DEPTH; i++) step(1'b1, JAL, 32'h100 + 32'(i) * 4, 32'h0);
    idle();
    chk("overflow pulse", 32'(rif.overflow), 32'd1);
    chk("overflow depth", 32'(rif.depth), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, JR_RA, 32'h0, 32'h120 - 32'(i) * 4);
      #1 chk("wrap pred_addr", rif.pred_addr, 32'h120 - 32'(i) * 4);
    end
    step(1'b1, JR_RA, 32'h0, 32'h100);
    #1 chk("drained pred_valid", 32'(rif.pred_valid), 32'd0);
    idle();
    chk("drained underflow", 32'(rif.underflow), 32'd1);
    chk("wrap hit_cnt", 32'(rif.hit_cnt), 32'd12);
    chk("wrap miss_cnt", 32'(rif.miss_cnt), 32'd4);

    // Mispredict, then jr through a non-$ra register.
    step(1'b1, JAL, 32'h14, 32'h0);
    step(1'b1, JR_RA, 32'h0, 32'h80);
    #1 chk("mispredict pred_addr", rif.pred_addr, 32'h14);
    idle();
    chk("mispredict pulse", 32'(rif.mispredict), 32'd1);
    chk("mispredict miss_cnt", 32'(rif.miss_cnt), 32'd5);
    chk("mispredict depth", 32'(rif.depth), 32'd0);
    step(1'b1, JAL, 32'h14, 32'h0);
    step(1'b1, JR_T0, 32'h0, 32'h14);
    #1 chk("jr t0 pred_valid", 32'(rif.pred_valid), 32'd0);
    idle();
    chk("jr t0 depth", 32'(rif.depth), 32'd1);

    // en=0 blocks state change; async reset clears mid-cycle.
    step(1'b0, JAL, 32'h50, 32'h0);
    idle();
    chk("en0 depth", 32'(rif.depth), 32'd1);
    step(1'b1, JAL, 32'h60, 32'h0);
    step(1'b1, JAL, 32'h70, 32'h0);
    idle();
    chk("pre-reset depth", 32'(rif.depth), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("async reset depth", 32'(rif.depth), 32'd0);
    chk("async reset hit_cnt", 32'(rif.hit_cnt), 32'd0);
    chk("async reset miss_cnt", 32'(rif.miss_cnt), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    step(1'b1, JAL, 32'h200, 32'h0);
    step(1'b1, JR_RA, 32'h0, 32'h200);
    #1 chk("post-reset pred_addr", rif.pred_addr, 32'h200);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack (RAS) for the single-cycle MIPS core: the return end of the call protocol that jal starts.
- jal pushes pc+4; jr $ra pops and predicts the return target.
- Sits beside the controller/datapath. It watches retiring instructions and compares each prediction with the real $ra value read from the regfile.
- Produces a prediction, error pulses and hit/miss statistics for later use by a fetch-side predictor.

Parameters:
DEPTH, 8, number of stack entries (power of 2, minimum 2)
PTRW, 3, log2(DEPTH); pointer width
CNTW, 16, width of the hit and miss statistic counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
en  input  1  instruction on instr retires this cycle
instr  input  32  current instruction word
pcplus4  input  32  pc+4 of the current instruction (the value pushed)
ra_actual  input  32  regfile read of rs (srca) this cycle; the true jr target
pred_valid  output  1  combinational: current instr is jr $ra and the stack is non-empty
pred_addr  output  32  combinational: top-of-stack entry; 0 when pred_valid=0
depth  output  PTRW+1  number of valid entries, 0..DEPTH
mispredict  output  1  registered 1-cycle pulse: the previous pop's prediction did not equal ra_actual
underflow  output  1  registered 1-cycle pulse: the previous jr $ra found the stack empty
overflow  output  1  registered 1-cycle pulse: the previous push overwrote the oldest entry
hit_cnt  output  CNTW  saturating count of correct predictions
miss_cnt  output  CNTW  saturating count of mispredicts plus underflows

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: storage array is don't-care; tos=0; depth=0; mispredict=underflow=overflow=0; hit_cnt=miss_cnt=0.
- Decode is internal:
  - is_call = instr[31:26]==6'b000011 (jal).
  - is_ret = instr[31:26]==0 && instr[5:0]==6'b001000 && instr[25:21]==31 (jr $ra only).
  - jr with any other rs is ignored. All other opcodes do nothing.
- Storage is a circular buffer. tos points to the next free slot. The top entry is stack[tos-1], modulo DEPTH.
- Push, on the clock edge when en && is_call:
  - stack[tos] <= pcplus4; tos <= tos+1, wrapping mod DEPTH.
  - If depth<DEPTH: depth <= depth+1.
  - If depth==DEPTH: depth is unchanged, the oldest entry is silently lost, and overflow pulses on the next cycle.
- Pop, on the clock edge when en && is_ret:
  - If depth>0: tos <= tos-1 and depth <= depth-1.
    - pred_addr==ra_actual: hit_cnt increments.
    - Otherwise: mispredict pulses next cycle and miss_cnt increments.
  - If depth==0: tos and depth are unchanged, underflow pulses next cycle, and miss_cnt increments.
- Prediction has zero latency: pred_valid and pred_addr are combinational from is_ret, depth and the stack.
- Each pulse output is high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Counters saturate at all-ones and never wrap.
- en=0: no state change at all, even if instr decodes as jal or jr.
- is_call and is_ret are mutually exclusive by opcode, so no simultaneous push and pop arises.
- Push then pop of the same entry on consecutive cycles must return the pushed value: write-then-read through the array, no bypass needed.
- Pointer wrap: tos goes from DEPTH-1 to 0 on push and from 0 to DEPTH-1 on pop. depth is independent of the wrap.
- Reset asserted mid-sequence: all of the above clears immediately, with no need for a clock edge. Any pending pulse is cancelled.

Decomposition:
- Shared package mips_pkg:
  - OP_RTYPE=6'b000000, OP_JAL=6'b000011, FUNCT_JR=6'b001000, REG_RA=5'd31.
  - The is_call / is_ret decode helper, reusable by maindec.
- One natural sub-module: ras_storage. It holds the DEPTH x 32 array with one synchronous write port and one combinational read port, indexed by pointer.
- Pointer, depth, pulse and counter logic stay in the top block.

Test Plan:
- After reset: depth=0, pred_valid=0, hit_cnt=miss_cnt=0; a jr $ra (instr=0x03E00008, ra_actual=0x40) -> underflow pulse next cycle, miss_cnt=1, depth=0.
- jal at pc=0x10 (pcplus4=0x14) then jr $ra with ra_actual=0x14 -> pred_valid=1, pred_addr=0x14 during the jr, hit_cnt=1, mispredict stays 0, depth back to 0.
- Nested calls: jal with pcplus4=0x14, 0x24, 0x34, then three jr $ra with ra_actual 0x34, 0x24, 0x14 -> predictions 0x34, 0x24, 0x14 in that order, hit_cnt=3.
- DEPTH+1=9 pushes (pcplus4=0x100, 0x104, …, 0x120) -> overflow pulse after the 9th, depth=8; 9 pops -> predictions 0x120 down to 0x104, then underflow on the 9th pop.
- jr $ra with stack top 0x14 but ra_actual=0x80 -> mispredict pulse, miss_cnt+1, depth decrements. A jr $t0 (instr=0x01000008) -> no pop, pred_valid=0.
- en=0 with a jal on instr -> depth unchanged. Reset asserted between clock edges with depth=3 -> depth=0 immediately; counters=0.
